// File: rtl/game_ctrl_if.sv
// Player/board bus of the tic-tac-toe referee: requests and board image in, board write port and game status out.
interface game_ctrl_if;
    logic        new_game;
    logic        req_valid;
    logic        req_player;
    logic [1:0]  req_row;
    logic [1:0]  req_col;
    logic [17:0] registers;
    logic        write_error;
    logic        board_clr;
    logic [1:0]  xoro;
    logic [1:0]  row;
    logic [1:0]  col;
    logic        input_error;
    logic        ack;
    logic        nak;
    logic [1:0]  nak_code;
    logic        turn;
    logic [1:0]  winner;
    logic        draw;
    logic        game_over;
    logic [3:0]  move_count;
    logic [3:0]  score_x;
    logic [3:0]  score_o;

    modport slave (
        input  new_game, req_valid, req_player, req_row, req_col, registers, write_error,
        output board_clr, xoro, row, col, input_error, ack, nak, nak_code,
        output turn, winner, draw, game_over, move_count, score_x, score_o
    );

    modport master (
        output new_game, req_valid, req_player, req_row, req_col, registers, write_error,
        input  board_clr, xoro, row, col, input_error, ack, nak, nak_code,
        input  turn, winner, draw, game_over, move_count, score_x, score_o
    );
endinterface

// File: rtl/game_ctrl.sv
// Tic-tac-toe turn scheduler and referee driving the 3x3 board write port.
// Define GAME_SCORE_EN to build the saturating per-player win counters.
module game_ctrl #(
    parameter bit FIRST_PLAYER = 1'b0,
    parameter int TIMEOUT      = 255
) (
    input  logic        ph1,
    input  logic        reset,
    game_ctrl_if.slave  bus
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_WAIT,
        S_WRITE,
        S_CHECK,
        S_OVER
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_turn, w_turn_nxt;
    logic [1:0]    r_winner, w_winner_nxt;
    logic          r_draw, w_draw_nxt;
    logic          r_game_over, w_game_over_nxt;
    logic [3:0]    r_move_count, w_move_count_nxt;
    logic          r_ack, w_ack_nxt;
    logic          r_nak, w_nak_nxt;
    logic [1:0]    r_nak_code, w_nak_code_nxt;
    logic [1:0]    r_row, w_row_nxt;
    logic [1:0]    r_col, w_col_nxt;
    logic [TW-1:0] r_tmo, w_tmo_nxt;
    logic [8:0]    w_mask;
    logic          w_req_live;
    logic          w_wr;

    function automatic logic line_win(input logic [8:0] m);
        return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
               (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
               (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
    endfunction

    // Cells owned by the player whose move is being checked
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < 9; i++) begin
            w_mask[i] = r_turn ? bus.registers[2*i+1] : bus.registers[2*i];
        end
    end

    // A request still held during its own ack/nak cycle must not be evaluated twice
    assign w_req_live = bus.req_valid && !r_ack && !r_nak;

    always_comb begin
        w_state_nxt      = r_state;
        w_turn_nxt       = r_turn;
        w_winner_nxt     = r_winner;
        w_draw_nxt       = r_draw;
        w_game_over_nxt  = r_game_over;
        w_move_count_nxt = r_move_count;
        w_ack_nxt        = 1'b0;
        w_nak_nxt        = 1'b0;
        w_nak_code_nxt   = 2'b00;
        w_row_nxt        = r_row;
        w_col_nxt        = r_col;
        w_tmo_nxt        = r_tmo;

        case (r_state)
            S_CLEAR: begin
                w_state_nxt      = S_WAIT;
                w_turn_nxt       = FIRST_PLAYER;
                w_winner_nxt     = 2'b00;
                w_draw_nxt       = 1'b0;
                w_game_over_nxt  = 1'b0;
                w_move_count_nxt = 4'd0;
            end
            S_WAIT: begin
                if (w_req_live && (bus.req_player != r_turn)) begin
                    w_nak_nxt      = 1'b1;
                    w_nak_code_nxt = 2'b01;
                end else if (w_req_live && ((bus.req_row == 2'd3) || (bus.req_col == 2'd3))) begin
                    w_nak_nxt      = 1'b1;
                    w_nak_code_nxt = 2'b10;
                end else if (w_req_live) begin
                    w_row_nxt   = bus.req_row;
                    w_col_nxt   = bus.req_col;
                    w_state_nxt = S_WRITE;
                end
                if (!(bus.req_valid && (bus.req_player == r_turn))) begin
                    w_tmo_nxt = r_tmo + TW'(1);
                    if ((TIMEOUT != 0) && (w_tmo_nxt == TMO_LIM)) begin
                        w_winner_nxt    = r_turn ? 2'b01 : 2'b10;
                        w_game_over_nxt = 1'b1;
                        w_state_nxt     = S_OVER;
                    end
                end
            end
            S_WRITE: begin
                if (bus.write_error) begin
                    w_nak_nxt      = 1'b1;
                    w_nak_code_nxt = 2'b11;
                    w_state_nxt    = S_WAIT;
                end else begin
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                w_move_count_nxt = r_move_count + 4'd1;
                if (line_win(w_mask)) begin
                    w_winner_nxt    = r_turn ? 2'b10 : 2'b01;
                    w_game_over_nxt = 1'b1;
                    w_state_nxt     = S_OVER;
                end else if (r_move_count == 4'd8) begin
                    w_draw_nxt      = 1'b1;
                    w_game_over_nxt = 1'b1;
                    w_state_nxt     = S_OVER;
                end else begin
                    w_turn_nxt  = ~r_turn;
                    w_state_nxt = S_WAIT;
                end
            end
            S_OVER: begin
                if (w_req_live) begin
                    w_nak_nxt      = 1'b1;
                    w_nak_code_nxt = 2'b01;
                end
            end
            default: w_state_nxt = S_CLEAR;
        endcase

        if (w_state_nxt != S_WAIT) begin
            w_tmo_nxt = '0;
        end

        if (bus.new_game) begin
            w_state_nxt    = S_CLEAR;
            w_ack_nxt      = 1'b0;
            w_nak_nxt      = 1'b0;
            w_nak_code_nxt = 2'b00;
        end
    end

    always_ff @(posedge ph1) begin
        if (reset) begin
            r_state      <= S_CLEAR;
            r_turn       <= FIRST_PLAYER;
            r_winner     <= 2'b00;
            r_draw       <= 1'b0;
            r_game_over  <= 1'b0;
            r_move_count <= 4'd0;
            r_ack        <= 1'b0;
            r_nak        <= 1'b0;
            r_nak_code   <= 2'b00;
            r_tmo        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_turn       <= w_turn_nxt;
            r_winner     <= w_winner_nxt;
            r_draw       <= w_draw_nxt;
            r_game_over  <= w_game_over_nxt;
            r_move_count <= w_move_count_nxt;
            r_ack        <= w_ack_nxt;
            r_nak        <= w_nak_nxt;
            r_nak_code   <= w_nak_code_nxt;
            r_tmo        <= w_tmo_nxt;
        end
    end

    always_ff @(posedge ph1) begin
        r_row <= w_row_nxt;
        r_col <= w_col_nxt;
    end

    // A WRITE overtaken by new_game is suppressed so the board never sees it
    assign w_wr            = (r_state == S_WRITE) && !bus.new_game;
    assign bus.board_clr   = reset || (r_state == S_CLEAR);
    assign bus.xoro        = w_wr ? (r_turn ? 2'b10 : 2'b01) : 2'b00;
    assign bus.row         = w_wr ? r_row : 2'b00;
    assign bus.col         = w_wr ? r_col : 2'b00;
    assign bus.input_error = !w_wr;
    assign bus.ack         = r_ack;
    assign bus.nak         = r_nak;
    assign bus.nak_code    = r_nak_code;
    assign bus.turn        = r_turn;
    assign bus.winner      = r_winner;
    assign bus.draw        = r_draw;
    assign bus.game_over   = r_game_over;
    assign bus.move_count  = r_move_count;

`ifdef GAME_SCORE_EN
    logic [3:0] r_score_x, r_score_o;
    logic       w_enter_over;

    assign w_enter_over = (w_state_nxt == S_OVER) && (r_state != S_OVER);

    // Scores survive new_game; only reset clears them
    always_ff @(posedge ph1) begin
        if (reset) begin
            r_score_x <= 4'd0;
            r_score_o <= 4'd0;
        end else if (w_enter_over) begin
            if ((w_winner_nxt == 2'b01) && (r_score_x != 4'hF)) r_score_x <= r_score_x + 4'd1;
            if ((w_winner_nxt == 2'b10) && (r_score_o != 4'hF)) r_score_o <= r_score_o + 4'd1;
        end
    end

    assign bus.score_x = r_score_x;
    assign bus.score_o = r_score_o;
`else
    assign bus.score_x = 4'd0;
    assign bus.score_o = 4'd0;
`endif

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Turn scheduler and referee for the 3x3 tic-tac-toe board storage block.
- Arbitrates move requests from two players (X, O) and drives the board write port (xoro, row, col, input_error).
- Uses the board's write_error to accept or reject each move and reads back the 18-bit board image to detect win or draw.
- Sits between player input logic and the board; one clock domain.

Parameters:
- FIRST_PLAYER, 0, player who moves first after clear (0 = X, 1 = O).
- TIMEOUT, 255, cycles allowed in WAIT for the current player before forfeit; 0 disables the timeout.

Ports:
- ph1  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- new_game  in  1  request to clear the board and restart; honoured in any state.
- req_valid  in  1  move request; held until ack or nak.
- req_player  in  1  requester identity (0 = X, 1 = O).
- req_row  in  2  requested row, 0..2.
- req_col  in  2  requested column, 0..2.
- registers  in  18  board image; cell i = row*3+col at bits [2i+1:2i]; bit0 = X, bit1 = O.
- write_error  in  1  combinational reject from the board.
- board_clr  out  1  board reset drive.
- xoro  out  2  board write select (01 = X, 10 = O, 00 = idle).
- row  out  2  board row.
- col  out  2  board column.
- input_error  out  1  board write inhibit.
- ack  out  1  one-cycle pulse: move accepted.
- nak  out  1  one-cycle pulse: move rejected.
- nak_code  out  2  valid with nak: 01 wrong turn, 10 out of range, 11 occupied.
- turn  out  1  player to move.
- winner  out  2  01 = X, 10 = O, 00 = none.
- draw  out  1  board full with no winner.
- game_over  out  1  game finished; requests rejected.
- move_count  out  4  accepted moves this game, 0..9.
- score_x  out  4  see Optional Feature.
- score_o  out  4  see Optional Feature.

Behaviour:
- Reset: state=CLEAR, board_clr=1, xoro=00, row=col=00, input_error=1, ack=nak=0, nak_code=00, turn=FIRST_PLAYER, winner=00, draw=0, game_over=0, move_count=0, timeout counter=0.
- States: CLEAR, WAIT, WRITE, CHECK, OVER.
- CLEAR: board_clr=1 for exactly one cycle. Clear turn, winner, draw, game_over, move_count. Go to WAIT.
- WAIT: xoro=00, input_error=1. Requests are ignored in any cycle where ack or nak is high. Otherwise, on req_valid:
  - req_player!=turn: nak, code 01; stay in WAIT.
  - row or col == 3: nak, code 10; stay in WAIT.
  - else: capture row/col and go to WRITE.
- WRITE (one cycle): xoro = turn ? 10 : 01, drive captured row/col, input_error=0. Sample write_error in the same cycle.
  - write_error=1: nak, code 11, next cycle; go to WAIT; turn unchanged.
  - write_error=0: go to CHECK.
- CHECK: the board image now includes the new move (one-cycle board latency). Pulse ack, increment move_count, and evaluate all 8 lines (3 rows, 3 cols, 2 diagonals) for the mover's bit.
  - Line complete: winner=mover, game_over=1, go to OVER.
  - Else if move_count becomes 9: draw=1, game_over=1, go to OVER.
  - Else: toggle turn, go to WAIT.
- OVER: xoro=00. Any req_valid gets nak, code 01. Stays in OVER until new_game.
- Timeout: the counter increments each WAIT cycle without a req_valid from the current player and clears on leaving WAIT. When it reaches TIMEOUT (nonzero): winner = other player, game_over=1, go to OVER.
- new_game: takes priority over everything except reset. Next state is CLEAR from any state; an in-flight WRITE is abandoned with no ack/nak.
- reset mid-game: returns to reset values; board_clr=1 for the whole time reset is high.
- Simultaneous win and 9th move: reported as a win, draw=0.

Optional Feature:
- Macro: GAME_SCORE_EN.
- Defined: score_x/score_o are 4-bit counters, incremented on entry to OVER with the matching winner and saturating at 15. They clear only on reset; new_game does not clear them.
- Undefined: score_x = score_o = 0 constant and no counter logic is built.

Test Plan:
- reset, then X requests (1,1): WRITE drives xoro=01/row=1/col=1, ack 2 cycles after req, registers[9:8]=01, turn=1, move_count=1.
- O requests (1,1) after the above: nak, code 11; turn stays 1. X request while turn=1: nak, code 01. Request with row=3: nak, code 10.
- X takes (0,0),(0,1),(0,2); O takes (1,0),(1,1) interleaved: after X's 3rd ack, winner=01, game_over=1; further requests nak, code 01.
- Nine alternating moves with no line (X:0,2,3,7,8; O:1,4,5,6 by index): draw=1, winner=00, move_count=9.
- TIMEOUT=4 with no requests: 4 cycles after WAIT entry, winner=10, game_over=1. Then new_game: board_clr one cycle, turn=FIRST_PLAYER, all flags clear.
- GAME_SCORE_EN: 16 X wins separated by new_game: score_x saturates at 15; reset returns it to 0.
